cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the 8-bit core's datapath: PC, IR, 4x8 GPR file, adder ALU, 32-byte data memory.
- Replaces flat single-cycle decode with FETCH/DECODE/EXEC/MEM/WB sequencing.
- Adds req/ack handshakes to instruction and data memory, plus run/step/halt control.
- Sits between the IR opcode field and the datapath enables; runs on the divided core clock.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/seq_timeout.sv | 33 +++
 rtl/cpu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core's multi-cycle sequencer.
// Contents: FSM state encodings, IR opcode constants and the 2-bit sign-extend helper
// used by the branch/offset immediate.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_BR  = 2'b11;

  // Sign-extend the 2-bit IR immediate to the 8-bit datapath width.
  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

endpackage

// File: rtl/seq_timeout.sv
// Memory-wait watchdog: counts cycles spent waiting for an imem/dmem ack.
// Ports: clock/reset; clear (hold count at 0 outside wait states), waiting (a request is
// outstanding), ack (request completed); expired (last allowed cycle passed with no ack).
module seq_timeout #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  input  logic ack,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] wait_cnt;

  // Counter value k means k earlier cycles of this wait went unanswered, so the
  // MEM_TIMEOUT-th waiting cycle is the last one; an ack in that cycle still wins.
  assign expired = waiting && !ack && (wait_cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (clear || ack) begin
      wait_cnt <= 8'd0;
    end else if (waiting && !expired) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 8-bit core, with imem/dmem
// req/ack handshakes, run/step/halt control and a sticky FAULT on memory timeout.
// Ports: clock, reset (async, active-high); run, step; ir_op, ir_imm from the IR; imem_ack,
// dmem_ack from memory; datapath strobes (imem_req, ir_load, pc_write, pc_branch,
// reg_write, reg_dst, mem_to_reg, alu_src, dmem_req, dmem_we); halted, fault, state.
// Optional: define SEQ_PERF_CNT_EN to add the retired / stall_cycles counter outputs.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [1:0]       ir_op,
  input  logic [1:0]       ir_imm,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
    $error("cpu_sequencer: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  state_t cur_state;
  logic   step_pend;  // one-deep latch for a step pulse seen mid-instruction
  logic   self_halt;  // parked after a branch-to-self until run drops or a step arrives

  logic   in_wait;
  logic   ack_sel;
  logic   expired;
  logic   br_self;
  state_t end_next;

  assign in_wait  = (cur_state == S_FETCH) || (cur_state == S_MEM);
  assign ack_sel  = (cur_state == S_FETCH) ? imem_ack :
                    (cur_state == S_MEM)   ? dmem_ack : 1'b0;
  assign br_self  = (sext2(ir_imm) == 8'hFF);
  assign end_next = (run && !step_pend && !step) ? S_FETCH : S_IDLE;

  seq_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_wait),
    .waiting (in_wait),
    .ack     (ack_sel),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= S_IDLE;
      step_pend <= 1'b0;
      self_halt <= 1'b0;
    end else begin
      if (step && cur_state != S_IDLE) begin
        step_pend <= 1'b1;
      end
      case (cur_state)
        S_IDLE: begin
          if (!run) begin
            self_halt <= 1'b0;
          end
          if (step || step_pend) begin
            cur_state <= S_FETCH;
            step_pend <= 1'b0;
            self_halt <= 1'b0;
          end else if (run && !self_halt) begin
            cur_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            cur_state <= S_DECODE;
          end else if (expired) begin
            cur_state <= S_FAULT;
          end
        end
        S_DECODE: cur_state <= S_EXEC;
        S_EXEC: begin
          if (ir_op == OP_BR) begin
            if (br_self) begin
              cur_state <= S_IDLE;
              self_halt <= 1'b1;
            end else begin
              cur_state <= end_next;
            end
          end else if (ir_op == OP_ADD) begin
            cur_state <= S_WB;
          end else begin
            cur_state <= S_MEM;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            cur_state <= (ir_op == OP_ST) ? end_next : S_WB;
          end else if (expired) begin
            cur_state <= S_FAULT;
          end
        end
        S_WB:    cur_state <= end_next;
        S_FAULT: cur_state <= S_FAULT;
        default: cur_state <= S_FAULT;
      endcase
    end
  end

  // Strobes decode from the registered state and IR opcode. The only two that also look
  // at an ack are ir_load and the store's pc_write, which must coincide with the cycle
  // the memory completes, and they are never asserted without the matching request.
  assign imem_req   = (cur_state == S_FETCH);
  assign ir_load    = (cur_state == S_FETCH) && imem_ack;
  assign pc_branch  = (cur_state == S_EXEC) && (ir_op == OP_BR);
  assign pc_write   = pc_branch
                    || ((cur_state == S_MEM) && (ir_op == OP_ST) && dmem_ack)
                    || (cur_state == S_WB);
  assign reg_write  = (cur_state == S_WB);
  assign reg_dst    = (cur_state == S_WB) && (ir_op == OP_ADD);
  assign mem_to_reg = (cur_state == S_WB) && (ir_op == OP_LD);
  assign alu_src    = (cur_state == S_EXEC) && (ir_op != OP_ADD);
  assign dmem_req   = (cur_state == S_MEM);
  assign dmem_we    = (cur_state == S_MEM) && (ir_op == OP_ST);
  assign halted     = (cur_state == S_IDLE);
  assign fault      = (cur_state == S_FAULT);
  assign state      = cur_state;

`ifdef SEQ_PERF_CNT_EN
  // Every pc_write ends an instruction, so it doubles as the retire event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (pc_write && !(&retired)) begin
        retired <= retired + 1'b1;
      end
      if (in_wait && !ack_sel && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic run, step;
  logic [1:0] ir_op, ir_imm;
  logic imem_ack, dmem_ack;
  logic imem_req, ir_load, pc_write, pc_branch, reg_write, reg_dst;
  logic mem_to_reg, alu_src, dmem_req, dmem_we, halted, fault;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] retired, stall_cycles;
`endif

  always #5 clock = ~clock;

  cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .ir_op(ir_op), .ir_imm(ir_imm), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_branch(pc_branch),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .halted(halted), .fault(fault), .state(state)
`ifdef SEQ_PERF_CNT_EN
    , .retired(retired), .stall_cycles(stall_cycles)
`endif
  );

  // Output bundle bit positions
  localparam logic [11:0] IRQ  = 12'h800, ILD = 12'h400, PCW  = 12'h200, PCB = 12'h100;
  localparam logic [11:0] RGW  = 12'h080, RDS = 12'h040, M2R  = 12'h020, ASRC = 12'h010;
  localparam logic [11:0] DRQ  = 12'h008, DWE = 12'h004, HLT  = 12'h002, FLT = 12'h001;

  logic [11:0] obs;
  assign obs = {imem_req, ir_load, pc_write, pc_branch, reg_write, reg_dst,
                mem_to_reg, alu_src, dmem_req, dmem_we, halted, fault};

  typedef struct {
    logic       run;
    logic       step;
    logic [1:0] op;
    logic [1:0] imm;
    logic       iack;
    logic       dack;
    logic [2:0] exp_state;
    logic [11:0] exp_out;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t V(logic r, logic s, logic [1:0] op, logic [1:0] imm,
                             logic ia, logic da, logic [2:0] st, logic [11:0] o);
    vec_t v;
    v.run = r; v.step = s; v.op = op; v.imm = imm; v.iack = ia; v.dack = da;
    v.exp_state = st; v.exp_out = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; ir_op = 2'b00; ir_imm = 2'b00;
    imem_ack = 1'b0; dmem_ack = 1'b0;

    // ---- vector table: one entry per cycle, expected state/outputs within that cycle
    // add, run=1, zero-wait: 1,2,3,5 then fetch again
    vecs.push_back(V(1,0,2'd0,2'd0,1,1, 3'd0, HLT));
    vecs.push_back(V(1,0,2'd0,2'd0,1,1, 3'd1, IRQ|ILD));
    vecs.push_back(V(1,0,2'd0,2'd0,1,1, 3'd2, 12'h000));
    vecs.push_back(V(1,0,2'd0,2'd0,1,1, 3'd3, 12'h000));
    vecs.push_back(V(1,0,2'd0,2'd0,1,1, 3'd5, PCW|RGW|RDS));
    // load, dmem_ack 3 cycles late: 8 cycles, dmem_req 4 cycles, run dropped in WB
    vecs.push_back(V(1,0,2'd1,2'd0,1,1, 3'd1, IRQ|ILD));
    vecs.push_back(V(1,0,2'd1,2'd0,1,0, 3'd2, 12'h000));
    vecs.push_back(V(1,0,2'd1,2'd0,1,0, 3'd3, ASRC));
    vecs.push_back(V(1,0,2'd1,2'd0,1,0, 3'd4, DRQ));
    vecs.push_back(V(1,0,2'd1,2'd0,1,0, 3'd4, DRQ));
    vecs.push_back(V(1,0,2'd1,2'd0,1,0, 3'd4, DRQ));
    vecs.push_back(V(1,0,2'd1,2'd0,1,1, 3'd4, DRQ));
    vecs.push_back(V(0,0,2'd1,2'd0,1,1, 3'd5, PCW|RGW|M2R));
    // store by single step from halt
    vecs.push_back(V(0,1,2'd2,2'd0,1,1, 3'd0, HLT));
    vecs.push_back(V(0,0,2'd2,2'd0,1,1, 3'd1, IRQ|ILD));
    vecs.push_back(V(0,0,2'd2,2'd0,1,1, 3'd2, 12'h000));
    vecs.push_back(V(0,0,2'd2,2'd0,1,1, 3'd3, ASRC));
    vecs.push_back(V(0,0,2'd2,2'd0,1,1, 3'd4, DRQ|DWE|PCW));
    vecs.push_back(V(0,0,2'd2,2'd0,1,1, 3'd0, HLT));
    vecs.push_back(V(0,0,2'd2,2'd0,1,1, 3'd0, HLT));
    // branch-to-self with run=1: PC update then parked in IDLE
    vecs.push_back(V(1,0,2'd3,2'd3,1,1, 3'd0, HLT));
    vecs.push_back(V(1,0,2'd3,2'd3,1,1, 3'd1, IRQ|ILD));
    vecs.push_back(V(1,0,2'd3,2'd3,1,1, 3'd2, 12'h000));
    vecs.push_back(V(1,0,2'd3,2'd3,1,1, 3'd3, PCW|PCB|ASRC));
    vecs.push_back(V(1,0,2'd3,2'd3,1,1, 3'd0, HLT));
    vecs.push_back(V(1,0,2'd3,2'd3,1,1, 3'd0, HLT));
    // drop run to unpark, then an ordinary branch straight into the next fetch
    vecs.push_back(V(0,0,2'd3,2'd1,1,1, 3'd0, HLT));
    vecs.push_back(V(1,0,2'd3,2'd1,1,1, 3'd0, HLT));
    vecs.push_back(V(1,0,2'd3,2'd1,1,1, 3'd1, IRQ|ILD));
    vecs.push_back(V(1,0,2'd3,2'd1,1,1, 3'd2, 12'h000));
    vecs.push_back(V(1,0,2'd3,2'd1,1,1, 3'd3, PCW|PCB|ASRC));
    // run dropped mid-instruction: add still completes, then IDLE
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd1, IRQ|ILD));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd2, 12'h000));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd3, 12'h000));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd5, PCW|RGW|RDS));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd0, HLT));
    // step pulse during an instruction is latched and consumed at the next IDLE
    vecs.push_back(V(1,0,2'd0,2'd0,1,1, 3'd0, HLT));
    vecs.push_back(V(1,1,2'd0,2'd0,1,1, 3'd1, IRQ|ILD));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd2, 12'h000));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd3, 12'h000));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd5, PCW|RGW|RDS));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd0, HLT));
    vecs.push_back(V(0,0,2'd0,2'd0,0,1, 3'd1, IRQ));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd1, IRQ|ILD));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd2, 12'h000));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd3, 12'h000));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd5, PCW|RGW|RDS));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd0, HLT));
    vecs.push_back(V(0,0,2'd0,2'd0,1,1, 3'd0, HLT));

    // ---- reset state
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(obs), 32'(HLT));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // ---- table run
    foreach (vecs[i]) begin
      run = vecs[i].run; step = vecs[i].step; ir_op = vecs[i].op; ir_imm = vecs[i].imm;
      imem_ack = vecs[i].iack; dmem_ack = vecs[i].dack;
      @(negedge clock);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d_outs", i), 32'(obs), 32'(vecs[i].exp_out));
      tick();
    end
    run = 1'b0; step = 1'b0;

    // ---- fetch timeout: 15 cycles of imem_req, then sticky FAULT until reset
    do_reset();
    run = 1'b1; ir_op = 2'b00; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      chk($sformatf("to_fetch%0d", k), 32'({state, imem_req}), 32'({3'd1, 1'b1}));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      imem_ack = (k == 1);
      @(negedge clock);
      chk($sformatf("to_fault%0d", k), 32'({state, obs}), 32'({3'd6, FLT}));
      tick();
    end
    imem_ack = 1'b0;
    reset = 1'b1;
    #1;
    chk("fault_cleared_by_reset", 32'({state, obs}), 32'({3'd0, HLT}));
    reset = 1'b0;
    run = 1'b0;
    tick();

    // ---- load MEM wait: ack on the last allowed cycle wins over the timeout
    do_reset();
    run = 1'b1; ir_op = 2'b01; imem_ack = 1'b1; dmem_ack = 1'b0;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      chk($sformatf("mem_wait%0d", k), 32'({state, obs}), 32'({3'd4, DRQ}));
      tick();
    end
    dmem_ack = 1'b1;
    @(negedge clock);
    chk("mem_ack_at_limit", 32'({state, obs}), 32'({3'd4, DRQ}));
    tick();
    run = 1'b0;
    @(negedge clock);
    chk("ack_wins_wb", 32'({state, obs}), 32'({3'd5, PCW|RGW|M2R}));
    tick();
    @(negedge clock);
    chk("ack_wins_idle", 32'(state), 32'd0);

    // ---- reset during a store's MEM: immediate IDLE, no write or PC update
    do_reset();
    run = 1'b0; step = 1'b1; ir_op = 2'b10; imem_ack = 1'b1; dmem_ack = 1'b0;
    tick();
    step = 1'b0;
    tick(); tick(); tick();
    @(negedge clock);
    chk("st_in_mem", 32'({state, obs}), 32'({3'd4, DRQ|DWE}));
    reset = 1'b1;
    #1;
    chk("st_reset_async", 32'({state, obs}), 32'({3'd0, HLT}));
    dmem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk($sformatf("st_reset_hold%0d", k), 32'({pc_write, dmem_req, dmem_we}), 32'd0);
    end
    reset = 1'b0;
    tick();
    @(negedge clock);
    chk("st_after_reset", 32'({state, obs}), 32'({3'd0, HLT}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
